// File: rtl/direct_mapped_cache.sv
// direct_mapped_cache: direct-mapped, write-back, write-allocate data cache.
// It sits between a single-word requester and a line-wide backing memory.
// A hit completes combinationally in the request cycle. A miss first writes
// back a dirty victim, if there is one. It then fills the line and completes
// as a hit on the following cycle.
// Optional statistics counters are compiled in when DIRECT_CACHE_STATS_EN is
// defined.
module direct_mapped_cache #(
  parameter int ADDRESS_SIZE    = 32,
  parameter int REGISTER_SIZE   = 32,
  parameter int REGS_PER_LINE   = 4,
  parameter int LINE_INDEX_SIZE = 2,
  parameter int LINE_LENGTH     = REGS_PER_LINE * REGISTER_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_SIZE-1:0]  address,
  input  logic [REGISTER_SIZE-1:0] data,
  input  logic                     write,
  input  logic                     request,
  output logic [REGISTER_SIZE-1:0] result,
  output logic                     satisfied,
  output logic [ADDRESS_SIZE-1:0]  mem_address,
  output logic [LINE_LENGTH-1:0]   mem_data,
  output logic                     mem_write,
  output logic                     mem_request,
  input  logic [LINE_LENGTH-1:0]   mem_result,
  input  logic                     mem_satisfied
`ifdef DIRECT_CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  // Address layout, LSB to MSB: byte offset, word offset, index, tag.
  localparam int BYTE_OFF_W = $clog2(REGISTER_SIZE / 8);
  localparam int WORD_OFF_W = $clog2(REGS_PER_LINE);
  localparam int OFFSET_W   = BYTE_OFF_W + WORD_OFF_W;
  localparam int TAG_W      = ADDRESS_SIZE - LINE_INDEX_SIZE - OFFSET_W;
  localparam int LINES      = 2 ** LINE_INDEX_SIZE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Per-line control bits (reset) and storage (not reset)
  logic [LINES-1:0]         valid_q;
  logic [LINES-1:0]         dirty_q;
  logic [TAG_W-1:0]         tag_q  [LINES];
  logic [LINE_LENGTH-1:0]   line_q [LINES];

  // Miss context captured when leaving IDLE. The requester may change its
  // address afterwards, so the in-flight transaction uses only these values.
  logic [TAG_W-1:0]           miss_tag_q;
  logic [LINE_INDEX_SIZE-1:0] miss_index_q;

  // Request address fields
  logic [TAG_W-1:0]           req_tag;
  logic [LINE_INDEX_SIZE-1:0] req_index;
  logic [WORD_OFF_W-1:0]      req_word;
  logic                       unused_byte_offset;

  logic hit;
  logic miss;
  logic victim_dirty;

  assign req_tag            = address[ADDRESS_SIZE-1 -: TAG_W];
  assign req_index          = address[OFFSET_W +: LINE_INDEX_SIZE];
  assign req_word           = address[BYTE_OFF_W +: WORD_OFF_W];
  assign unused_byte_offset = ^address[BYTE_OFF_W-1:0];

  // Requests are only looked up in IDLE. Reset masks them so that nothing is
  // reported or written while reset is held.
  assign hit = request && !reset && (state_q == IDLE) &&
               valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign miss = request && !reset && (state_q == IDLE) && !hit;
  assign victim_dirty = valid_q[req_index] && dirty_q[req_index];

  // Extract one register-sized word from a cache line
  function automatic logic [REGISTER_SIZE-1:0] select_word(
    input logic [LINE_LENGTH-1:0] line,
    input logic [WORD_OFF_W-1:0]  word
  );
    return line[int'(word) * REGISTER_SIZE +: REGISTER_SIZE];
  endfunction

  // Build a line-aligned memory address from a tag and an index
  function automatic logic [ADDRESS_SIZE-1:0] line_address(
    input logic [TAG_W-1:0]           tag,
    input logic [LINE_INDEX_SIZE-1:0] index
  );
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: miss sequencing, with an optional writeback before the fill
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (mem_satisfied) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_satisfied) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: requester response in IDLE, memory port drive during a miss
  always_comb begin
    satisfied   = 1'b0;
    result      = '0;
    mem_request = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state_q)
      IDLE: begin
        satisfied = hit;
        if (hit && !write) begin
          result = select_word(line_q[req_index], req_word);
        end
      end
      WRITEBACK: begin
        mem_request = 1'b1;
        mem_write   = 1'b1;
        mem_address = line_address(tag_q[miss_index_q], miss_index_q);
        mem_data    = line_q[miss_index_q];
      end
      FILL: begin
        mem_request = 1'b1;
        mem_address = line_address(miss_tag_q, miss_index_q);
      end
      default: begin
        satisfied = 1'b0;
      end
    endcase
  end

  // Valid/dirty bookkeeping: a store hit dirties the line, a writeback
  // cleans it, and a fill installs a clean, valid line
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (hit && write) begin
        dirty_q[req_index] <= 1'b1;
      end
      if ((state_q == WRITEBACK) && mem_satisfied) begin
        dirty_q[miss_index_q] <= 1'b0;
      end
      if ((state_q == FILL) && mem_satisfied) begin
        valid_q[miss_index_q] <= 1'b1;
        dirty_q[miss_index_q] <= 1'b0;
      end
    end
  end

  // Datapath storage: miss capture, store-hit word merge, line/tag install on fill
  always_ff @(posedge clk) begin
    if (miss) begin
      miss_tag_q   <= req_tag;
      miss_index_q <= req_index;
    end
    if (hit && write) begin
      line_q[req_index][int'(req_word) * REGISTER_SIZE +: REGISTER_SIZE] <= data;
    end
    if ((state_q == FILL) && mem_satisfied) begin
      line_q[miss_index_q] <= mem_result;
      tag_q[miss_index_q]  <= miss_tag_q;
    end
  end

`ifdef DIRECT_CACHE_STATS_EN
  // Statistics: one hit per satisfied cycle, one miss per departure from IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (satisfied) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb_direct_mapped_cache: directed bench for direct_mapped_cache. The cache
// is configured with two lines of four words. A reference model keeps the
// architectural memory view and the per-index residency state, and a backing
// memory responder serves fills and absorbs writebacks.
module tb_direct_mapped_cache;

  localparam int AW  = 32;
  localparam int RW  = 32;
  localparam int RPL = 4;
  localparam int LIS = 1;
  localparam int LL  = RPL * RW;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic [RW-1:0] data = '0;
  logic          write = 1'b0;
  logic          request = 1'b0;
  logic [RW-1:0] result;
  logic          satisfied;
  logic [AW-1:0] mem_address;
  logic [LL-1:0] mem_data;
  logic          mem_write;
  logic          mem_request;
  logic [LL-1:0] mem_result = '0;
  logic          mem_satisfied = 1'b0;

  always #5 clk = ~clk;

  direct_mapped_cache #(
    .ADDRESS_SIZE(AW),
    .REGISTER_SIZE(RW),
    .REGS_PER_LINE(RPL),
    .LINE_INDEX_SIZE(LIS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .data(data),
    .write(write),
    .request(request),
    .result(result),
    .satisfied(satisfied),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_write(mem_write),
    .mem_request(mem_request),
    .mem_result(mem_result),
    .mem_satisfied(mem_satisfied)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [LL-1:0] act, input logic [LL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: architectural words written by stores, backing memory lines,
  // and per-index residency (valid, dirty, tag)
  logic [31:0]   arch [logic [31:0]];
  logic [LL-1:0] bmem [logic [31:0]];
  bit            mvalid [2];
  bit            mdirty [2];
  logic [26:0]   mtag [2];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a < 32'd16) return (a == 32'd0) ? 32'd1 : 32'd0;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LL-1:0] bmem_line(input logic [31:0] la);
    logic [LL-1:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < RPL; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    logic [31:0]   a4;
    logic [LL-1:0] l;
    a4 = {a[31:2], 2'b00};
    if (arch.exists(a4)) return arch[a4];
    l = bmem_line({a[31:4], 4'b0000});
    return l[int'(a[3:2]) * 32 +: 32];
  endfunction

  function automatic logic [LL-1:0] arch_line(input logic [31:0] la);
    logic [LL-1:0] l;
    for (int w = 0; w < RPL; w++) l[w*32 +: 32] = arch_word(la + 32'(w * 4));
    return l;
  endfunction

  // Backing memory responder: completes each transaction LAT cycles after it starts
  int mcnt = 0;
  bit stray = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_request) begin
      if (mcnt == LAT - 1) begin
        mem_satisfied = 1'b1;
        mcnt = 0;
        if (mem_write) bmem[mem_address] = mem_data;
        else mem_result = bmem_line(mem_address);
      end else begin
        mem_satisfied = 1'b0;
        mcnt++;
      end
    end else begin
      mcnt = 0;
      mem_satisfied = stray;
      mem_result = stray ? {4{32'hBADB_AD00}} : '0;
    end
  end

  // Expectations shared between the driver and the compare process
  bit          chk_en = 1'b0;
  bit          req_active = 1'b0;
  bit          sat_seen = 1'b0;
  bit          wb_seen = 1'b0;
  bit          fill_seen = 1'b0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_wb_addr = '0;
  logic [31:0] exp_fill_addr = '0;
  logic [31:0] last_result = '0;
  logic [31:0] last_wb_addr = '0;
  logic [31:0] last_fill_addr = '0;
  logic [LL-1:0] last_wb_data = '0;

  // Compare process: checks the DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      if (!mem_request) begin
        chk("mem_idle_write", 128'(mem_write), 128'd0);
        chk("mem_idle_addr", 128'(mem_address), 128'd0);
        chk("mem_idle_data", mem_data, '0);
      end else begin
        chk("sat_during_miss", 128'(satisfied), 128'd0);
        if (mem_write) begin
          chk("wb_after_fill", 128'(fill_seen), 128'd0);
          wb_seen = 1'b1;
          last_wb_addr = mem_address;
          last_wb_data = mem_data;
          chk("wb_addr", 128'(mem_address), 128'(exp_wb_addr));
          chk("wb_data", mem_data, arch_line(exp_wb_addr));
        end else begin
          fill_seen = 1'b1;
          last_fill_addr = mem_address;
          chk("fill_addr", 128'(mem_address), 128'(exp_fill_addr));
        end
      end
      if (req_active && !sat_seen) begin
        chk("sat_timing", 128'(satisfied), 128'(acc_cyc == exp_lat));
        if (satisfied) begin
          sat_seen = 1'b1;
          if (!write) begin
            last_result = result;
            chk("load_data", 128'(result), 128'(arch_word(address)));
          end
        end
        acc_cyc++;
      end else if (!request) begin
        chk("sat_no_request", 128'(satisfied), 128'd0);
      end
    end
  end

  // One access from request to completion; called at posedge + 1
  task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] wd);
    int          idx;
    logic [26:0] tg;
    bit          resident;
    bit          ewb;
    idx = int'(a[4]);
    tg = a[31:5];
    resident = mvalid[idx] && (mtag[idx] == tg);
    ewb = !resident && mvalid[idx] && mdirty[idx];
    exp_wb_addr = {mtag[idx], a[4], 4'b0000};
    exp_fill_addr = {a[31:4], 4'b0000};
    exp_lat = resident ? 0 : (1 + LAT + (ewb ? LAT : 0));
    wb_seen = 1'b0;
    fill_seen = 1'b0;
    sat_seen = 1'b0;
    acc_cyc = 0;
    address = a;
    write = wr;
    data = wd;
    request = 1'b1;
    req_active = 1'b1;
    for (int n = 0; n < 40 && !sat_seen; n++) @(posedge clk);
    chk("completed", 128'(sat_seen), 128'd1);
    chk("wb_occurred", 128'(wb_seen), 128'(ewb));
    chk("fill_occurred", 128'(fill_seen), 128'(!resident));
    if (!resident) begin
      mvalid[idx] = 1'b1;
      mtag[idx] = tg;
      mdirty[idx] = 1'b0;
    end
    if (wr) begin
      arch[{a[31:2], 2'b00}] = wd;
      mdirty[idx] = 1'b1;
    end
    #1;
    request = 1'b0;
    write = 1'b0;
    req_active = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i] = '0;
    end
    arch.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_satisfied", 128'(satisfied), 128'd0);
    chk("reset_result", 128'(result), 128'd0);
    chk("reset_mem_request", 128'(mem_request), 128'd0);
    chk("reset_mem_write", 128'(mem_write), 128'd0);
    chk("reset_mem_address", 128'(mem_address), 128'd0);
    chk("reset_mem_data", mem_data, '0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Cold load miss: fill of line 0, then hit with word 0 = 1
    access(32'h0, 1'b0, '0);
    chk("cold_load_result", 128'(last_result), 128'h1);
    chk("cold_fill_addr", 128'(last_fill_addr), 128'h0);
    // Same-line hit on word 1
    access(32'h4, 1'b0, '0);
    chk("same_line_result", 128'(last_result), 128'h0);
    // Store hit, then read back
    access(32'h8, 1'b1, 32'hDEAD_BEEF);
    access(32'h8, 1'b0, '0);
    chk("store_readback", 128'(last_result), 128'hDEAD_BEEF);
    // Dirty eviction: index 0, tag 1
    access(32'h20, 1'b0, '0);
    chk("evict_wb_addr", 128'(last_wb_addr), 128'h0);
    chk("evict_wb_word2", 128'(last_wb_data[95:64]), 128'hDEAD_BEEF);
    chk("evict_fill_addr", 128'(last_fill_addr), 128'h20);
    chk("evict_result", 128'(last_result), 128'h5A5A_0020);
    // Clean eviction back to line 0; the written-back store comes from memory
    access(32'h0, 1'b0, '0);
    chk("clean_fill_addr", 128'(last_fill_addr), 128'h0);
    access(32'h8, 1'b0, '0);
    chk("refill_store_value", 128'(last_result), 128'hDEAD_BEEF);
    // Store miss on index 1, then dirty eviction of that line
    access(32'h10, 1'b1, 32'h1234_5678);
    access(32'h30, 1'b0, '0);
    chk("idx1_wb_addr", 128'(last_wb_addr), 128'h10);
    chk("idx1_wb_word0", 128'(last_wb_data[31:0]), 128'h1234_5678);

    // Stray mem_satisfied while idle must be ignored
    stray = 1'b1;
    @(posedge clk);
    #1;
    access(32'h34, 1'b0, '0);
    chk("stray_hit_result", 128'(last_result), 128'h5A5A_0034);
    repeat (2) @(posedge clk);
    #1;
    stray = 1'b0;
    @(posedge clk);
    #1;

    // Request dropped mid-miss: the line is still installed at the latched address
    exp_fill_addr = 32'h50;
    wb_seen = 1'b0;
    fill_seen = 1'b0;
    address = 32'h50;
    write = 1'b0;
    request = 1'b1;
    @(posedge clk);
    #1;
    request = 1'b0;
    address = 32'h7C;
    chk("abandon_fill_started", 128'(mem_request), 128'd1);
    for (int n = 0; n < 20 && mem_request; n++) begin
      @(posedge clk);
      #1;
    end
    chk("abandon_fill_done", 128'(mem_request), 128'd0);
    mvalid[1] = 1'b1;
    mtag[1] = 27'd2;
    mdirty[1] = 1'b0;
    access(32'h54, 1'b0, '0);
    chk("abandon_then_hit", 128'(last_result), 128'h5A5A_0054);

    // Reset during FILL abandons the miss; the same address misses again
    exp_fill_addr = 32'h40;
    address = 32'h40;
    request = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_fill_started", 128'(mem_request), 128'd1);
    reset = 1'b1;
    request = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_abandon", 128'(mem_request), 128'd0);
    reset = 1'b0;
    model_reset();
    access(32'h40, 1'b0, '0);
    chk("post_reset_fill_addr", 128'(last_fill_addr), 128'h40);
    chk("post_reset_result", 128'(last_result), 128'h5A5A_0040);
    access(32'h0, 1'b0, '0);
    chk("post_reset_line0", 128'(last_result), 128'h1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
